// File: rtl/hdlc_tx_framer_if.sv
// Byte-stream handshake between a payload source and the HDLC transmit framer.
interface hdlc_tx_framer_if;
    logic [7:0] Tx_Data;
    logic       Tx_DataValid;
    logic       Tx_DataLast;
    logic       Tx_DataReady;

    modport master (
        output Tx_Data,
        output Tx_DataValid,
        output Tx_DataLast,
        input  Tx_DataReady
    );

    modport slave (
        input  Tx_Data,
        input  Tx_DataValid,
        input  Tx_DataLast,
        output Tx_DataReady
    );
endinterface

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero insertion, optional CRC-16/X.25 FCS, abort.
// Tx/TxEN always carry the bit selected at the previous strobe.
module hdlc_tx_framer #(
    parameter int BIT_DIV = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    hdlc_tx_framer_if.slave        txBus,
    input  logic                   Tx_FCSen,
    input  logic                   Tx_AbortFrame,
    output logic                   Tx,
    output logic                   TxEN,
    output logic                   Tx_Done,
    output logic                   Tx_AbortedTrans,
    output logic [7:0]             Tx_FrameSize
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_FLAG = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] FCS        = 3'd3;
    localparam logic [2:0] END_FLAG   = 3'd4;
    localparam logic [2:0] ABORT      = 3'd5;

    logic [2:0]  state;
    logic [2:0]  nxtState;
    logic [3:0]  bitCnt;
    logic [3:0]  nxtCnt;
    logic [7:0]  divCnt;
    logic [7:0]  shiftReg;
    logic [7:0]  nxtShift;
    logic [7:0]  frameCnt;
    logic [2:0]  onesCnt;
    logic [15:0] crc;
    logic [15:0] crcNext;
    logic        lastByte;
    logic        fcsEn;
    logic        stuffSlot;
    logic        abortPend;
    logic        strobe;
    logic        abortable;
    logic        abortHit;
    logic        lastBit;
    logic        ready;
    logic        loadByte;
    logic        needStuff;
    logic        txBit;

    assign strobe    = (state != IDLE) && (divCnt == 8'(BIT_DIV - 1));
    assign abortable = (state == START_FLAG) || (state == DATA) || (state == FCS);
    assign abortHit  = strobe && abortable && (abortPend || Tx_AbortFrame);
    assign lastBit   = (state == FCS) ? (bitCnt == 4'd15) : (bitCnt == 4'd7);

    // stuffSlot means the position already points at the held payload bit
    assign ready = strobe && !stuffSlot && lastBit &&
                   ((state == START_FLAG) || ((state == DATA) && !lastByte));
    assign txBus.Tx_DataReady = ready;

    assign loadByte  = ready && txBus.Tx_DataValid && !abortHit;
    assign needStuff = !stuffSlot && ((state == DATA) || (state == FCS)) &&
                       (onesCnt == 3'd5) && !abortHit;
    assign nxtShift  = loadByte ? txBus.Tx_Data : shiftReg;

    always_comb begin
        nxtState = state;
        nxtCnt   = bitCnt;
        if (abortHit) begin
            nxtState = ABORT;
            nxtCnt   = 4'd0;
        end else if (!stuffSlot) begin
            if (!lastBit) begin
                nxtCnt = bitCnt + 4'd1;
            end else begin
                nxtCnt = 4'd0;
                unique case (state)
                    START_FLAG:
                        nxtState = txBus.Tx_DataValid ? DATA : ABORT;
                    DATA: begin
                        if (lastByte)
                            nxtState = fcsEn ? FCS : END_FLAG;
                        else
                            nxtState = txBus.Tx_DataValid ? DATA : ABORT;
                    end
                    FCS:     nxtState = END_FLAG;
                    default: nxtState = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        txBit = 1'b1;
        unique case (nxtState)
            START_FLAG, END_FLAG:
                txBit = (nxtCnt != 4'd0) && (nxtCnt != 4'd7);
            ABORT:   txBit = (nxtCnt != 4'd0);
            DATA:    txBit = nxtShift[nxtCnt[2:0]];
            FCS:     txBit = ~crc[nxtCnt];
            default: txBit = 1'b1;
        endcase
    end

    assign crcNext = (crc[0] ^ txBit) ? ({1'b0, crc[15:1]} ^ 16'h8408)
                                      : {1'b0, crc[15:1]};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state           <= IDLE;
            bitCnt          <= 4'd0;
            divCnt          <= 8'd0;
            shiftReg        <= 8'd0;
            frameCnt        <= 8'd0;
            onesCnt         <= 3'd0;
            crc             <= 16'd0;
            lastByte        <= 1'b0;
            fcsEn           <= 1'b0;
            stuffSlot       <= 1'b0;
            abortPend       <= 1'b0;
            Tx              <= 1'b1;
            TxEN            <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_FrameSize    <= 8'd0;
        end else begin
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            if (state == IDLE) begin
                divCnt    <= 8'd0;
                abortPend <= 1'b0;
                if (txBus.Tx_DataValid) begin
                    state     <= START_FLAG;
                    bitCnt    <= 4'd0;
                    Tx        <= 1'b0;
                    TxEN      <= 1'b1;
                    fcsEn     <= Tx_FCSen;
                    crc       <= 16'hFFFF;
                    onesCnt   <= 3'd0;
                    frameCnt  <= 8'd0;
                    stuffSlot <= 1'b0;
                end
            end else begin
                divCnt    <= strobe ? 8'd0 : divCnt + 8'd1;
                abortPend <= abortable && !strobe && (abortPend || Tx_AbortFrame);
                if (strobe) begin
                    state  <= nxtState;
                    bitCnt <= nxtCnt;
                    if (loadByte) begin
                        shiftReg <= txBus.Tx_Data;
                        lastByte <= txBus.Tx_DataLast;
                        if (frameCnt != 8'hFF)
                            frameCnt <= frameCnt + 8'd1;
                    end
                    if (nxtState == IDLE) begin
                        Tx        <= 1'b1;
                        TxEN      <= 1'b0;
                        stuffSlot <= 1'b0;
                        if (state == END_FLAG) begin
                            Tx_Done      <= 1'b1;
                            Tx_FrameSize <= frameCnt;
                        end else begin
                            Tx_AbortedTrans <= 1'b1;
                        end
                    end else if (needStuff) begin
                        Tx        <= 1'b0;
                        stuffSlot <= 1'b1;
                        onesCnt   <= 3'd0;
                    end else begin
                        Tx        <= txBit;
                        stuffSlot <= 1'b0;
                        if (nxtState == DATA)
                            crc <= crcNext;
                        if ((nxtState == DATA) || (nxtState == FCS))
                            onesCnt <= txBit ? onesCnt + 3'd1 : 3'd0;
                        else
                            onesCnt <= 3'd0;
                    end
                end
            end
        end
    end
endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
- Synthesizable HDLC transmit framer. Serialises bytes from a valid/ready byte stream onto the Tx line.
- Per frame it inserts opening and closing flags (0x7E), performs zero-insertion (bit stuffing) and optionally appends the 16-bit FCS.
- Supports abort on request and on underrun.
- It is the transmit counterpart of the HDLC receive path and drives the serial line the receiver samples.

Parameters:
- BIT_DIV, 1: clock cycles per line bit (1..255). A bit strobe fires every BIT_DIV cycles while not IDLE; all cycle numbers below assume BIT_DIV=1.

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous reset, active low
- Tx_Data  in  8  payload byte
- Tx_DataValid  in  1  Tx_Data valid
- Tx_DataLast  in  1  qualifies the current byte as the last payload byte of the frame
- Tx_DataReady  out  1  byte accepted this cycle (transfer = Valid & Ready)
- Tx_FCSen  in  1  append FCS; sampled when leaving IDLE
- Tx_AbortFrame  in  1  request abort of the frame in progress
- Tx  out  1  serial line, LSB first, registered
- TxEN  out  1  high while a flag/data/FCS/abort bit is on Tx, registered
- Tx_Done  out  1  one-cycle pulse: closing flag complete
- Tx_AbortedTrans  out  1  one-cycle pulse: abort sequence complete
- Tx_FrameSize  out  8  payload byte count of the last completed frame, saturates at 255

Behaviour:
Reset (Rst=0 at an edge):
- State IDLE; Tx=1, TxEN=0, Tx_DataReady=0, Tx_Done=0, Tx_AbortedTrans=0, Tx_FrameSize=0.
- All counters, shift register and CRC are cleared.
- Reset mid-frame truncates immediately; no abort pattern is sent.

States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE: Tx=1, TxEN=0. Tx_DataValid=1 → START_FLAG next cycle. The byte is not consumed. Tx_FCSen is latched. CRC is set to 0xFFFF and the ones counter to 0.
- START_FLAG: 8 bits 0,1,1,1,1,1,1,0. The first flag bit is on Tx the cycle after the IDLE detection. No stuffing.
- On the strobe of the final flag bit, Tx_DataReady=1 (combinational):
  - Valid=1: byte loads into the shift register and state goes to DATA.
  - Valid=0: underrun → ABORT.
- DATA: shift LSB first and update the CRC per payload bit (not per stuffed bit).
  - At the byte-final bit strobe, Tx_DataReady=1 unless the loaded byte had Last=1.
  - Last byte done → FCS if Tx_FCSen, else END_FLAG.
  - Not last and Valid=0 → ABORT (underrun).
- FCS: CRC-16/X.25 (reflected poly 0x8408, init 0xFFFF). The complement of the CRC is sent LSB first, 16 bits; low byte first.
- END_FLAG: 0x7E as in START_FLAG. Not abortable. Tx_Done pulses on the cycle after the last flag bit. Then IDLE, with at least one idle cycle (Tx=1, TxEN=0) before the next START_FLAG.
- ABORT: bits 0,1,1,1,1,1,1,1, no stuffing. Tx_AbortedTrans pulses on the cycle after the last bit. Then IDLE. Tx_FrameSize is not updated.

Zero insertion:
- Applies in DATA and FCS only.
- After five consecutive 1s, a 0 is emitted on the next bit slot. The payload bit is held, and no Ready or CRC update occurs in that slot.
- The ones counter spans byte boundaries and the DATA→FCS transition. It resets on any 0 sent, including a stuffed 0.
- If the fifth 1 is the last DATA/FCS bit, the stuffed 0 precedes the closing flag.

Tx_AbortFrame:
- Sampled in START_FLAG, DATA and FCS. The current bit completes, then ABORT starts on the next bit slot.
- Ignored in IDLE, END_FLAG and ABORT.
- Abort beats a simultaneous transfer: a byte accepted in the same cycle is dropped.

Tx_FrameSize:
- Counts transfers, saturating at 255.
- Updates on the Tx_Done cycle.

Test Plan:
- Hold Rst=0 for 3 cycles mid-frame → next cycle Tx=1, TxEN=0, Ready=0, Done=0, FrameSize=0. No abort bits appear.
- One byte 0x00, Last=1, FCSen=0 → Tx sequence 01111110 00000000 01111110. TxEN high exactly 24 cycles. Done pulses once. FrameSize=1.
- One byte 0xFF, Last=1, FCSen=0 → data field 1,1,1,1,1,0,1,1,1 (9 bits). TxEN high 25 cycles. Ready deasserted in the stuffed slot.
- ASCII "123456789", FCSen=1 → payload followed by FCS bytes 0x6E then 0x90, LSB first with stuffing. A monitor de-stuffing the line recovers 11 bytes, and the receiver reports no FCS error. FrameSize=9.
- Underrun: send byte 0x55 with Last=0, then drop Valid → after its 8th bit the line shows 0,1,1,1,1,1,1,1. AbortedTrans pulses once. No Done. FrameSize unchanged.
- Assert Tx_AbortFrame for 1 cycle during bit 3 of byte 2 → abort pattern begins 1 bit slot later. AbortedTrans pulses once. A following frame transmits correctly.
